pipe_reg_skid: RTL

PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

---
 rtl/pipe_reg_skid.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_reg_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_skid
//  Description : Two-entry registered pipeline stage (main + skid) between
//                the decode and execute stages. All outputs come straight
//                from flops, so there is no combinational path from any input
//                to any output. A taken-branch flush kills every held beat.
//                Two saturating performance counters track back-pressure
//                cycles and flushes that actually discarded work.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock, rising edge
//    rst        in   synchronous active-high reset
//    up_valid   in   upstream offers a beat
//    up_ready   out  block accepts a beat this cycle (registered)
//    up_data    in   packed operands {a, a2, b, b2}
//    up_ctrl    in   control bits of the upstream beat
//    flush      in   discard all held beats
//    dn_valid   out  head beat valid (registered)
//    dn_ready   in   downstream consumes the head beat
//    dn_data    out  operands of the head beat (zero when not valid)
//    dn_ctrl    out  control of the head beat (zero when not valid)
//    occupancy  out  number of held beats, 0..2
//    stall_cnt  out  saturating count of dn_valid & ~dn_ready cycles
//    flush_cnt  out  saturating count of flushes with occupancy != 0
// ============================================================================
module pipe_reg_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                up_valid,
    output logic                up_ready,
    input  logic [4*DATA_W-1:0] up_data,
    input  logic [CTRL_W-1:0]   up_ctrl,
    input  logic                flush,
    output logic                dn_valid,
    input  logic                dn_ready,
    output logic [4*DATA_W-1:0] dn_data,
    output logic [CTRL_W-1:0]   dn_ctrl,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    // State encoding equals the number of held beats, so the state register
    // doubles as the occupancy output.
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [4*DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [4*DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic                r_up_ready;
    logic                r_dn_valid;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic                w_accept;
    logic                w_consume;
    logic [1:0]          w_state_nxt;
    logic [4*DATA_W-1:0] w_main_data_nxt;
    logic [CTRL_W-1:0]   w_main_ctrl_nxt;
    logic [4*DATA_W-1:0] w_skid_data_nxt;
    logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
    logic [CNT_W-1:0]    w_stall_cnt_nxt;
    logic [CNT_W-1:0]    w_flush_cnt_nxt;

    // Handshakes use the registered ready/valid, which are exactly what the
    // neighbouring stages observe on the ports.
    assign w_accept  = up_valid & r_up_ready;
    assign w_consume = r_dn_valid & dn_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_main_data_nxt = r_main_data;
        w_main_ctrl_nxt = r_main_ctrl;
        w_skid_data_nxt = r_skid_data;
        w_skid_ctrl_nxt = r_skid_ctrl;

        case (r_state)
            c_ST_EMPTY: begin
                if (w_accept) begin
                    w_main_data_nxt = up_data;
                    w_main_ctrl_nxt = up_ctrl;
                    w_state_nxt     = c_ST_ONE;
                end
            end

            c_ST_ONE: begin
                if (w_accept && w_consume) begin
                    // Head leaves while the new beat replaces it in main.
                    w_main_data_nxt = up_data;
                    w_main_ctrl_nxt = up_ctrl;
                end else if (w_accept) begin
                    // Downstream stalled: park the new beat behind the head.
                    w_skid_data_nxt = up_data;
                    w_skid_ctrl_nxt = up_ctrl;
                    w_state_nxt     = c_ST_FULL;
                end else if (w_consume) begin
                    // Invalid entries are kept at zero so dn_* reads zero.
                    w_main_data_nxt = '0;
                    w_main_ctrl_nxt = '0;
                    w_state_nxt     = c_ST_EMPTY;
                end
            end

            c_ST_FULL: begin
                // up_ready is low here, so no accept can occur.
                if (w_consume) begin
                    w_main_data_nxt = r_skid_data;
                    w_main_ctrl_nxt = r_skid_ctrl;
                    w_skid_data_nxt = '0;
                    w_skid_ctrl_nxt = '0;
                    w_state_nxt     = c_ST_ONE;
                end
            end

            default: begin
                w_main_data_nxt = '0;
                w_main_ctrl_nxt = '0;
                w_skid_data_nxt = '0;
                w_skid_ctrl_nxt = '0;
                w_state_nxt     = c_ST_EMPTY;
            end
        endcase

        // Flush wins over every handshake: anything accepted or consumed in
        // this cycle is simply dropped along with the held beats.
        if (flush) begin
            w_main_data_nxt = '0;
            w_main_ctrl_nxt = '0;
            w_skid_data_nxt = '0;
            w_skid_ctrl_nxt = '0;
            w_state_nxt     = c_ST_EMPTY;
        end
    end

    // Counters look at the registered dn_valid/occupancy of the current
    // cycle, so a flush cycle with a stalled head still counts as a stall.
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        if (r_dn_valid && !dn_ready && (r_stall_cnt != c_CNT_MAX)) begin
            w_stall_cnt_nxt = r_stall_cnt + 1'b1;
        end
        if (flush && (r_state != c_ST_EMPTY) && (r_flush_cnt != c_CNT_MAX)) begin
            w_flush_cnt_nxt = r_flush_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_up_ready  <= 1'b1;
            r_dn_valid  <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_data_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            // Ready/valid are registered copies of the next state so the
            // ports never depend combinationally on inputs.
            r_up_ready  <= (w_state_nxt != c_ST_FULL);
            r_dn_valid  <= (w_state_nxt != c_ST_EMPTY);
            r_stall_cnt <= w_stall_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (pure register taps)
    // ------------------------------------------------------------------
    assign up_ready  = r_up_ready;
    assign dn_valid  = r_dn_valid;
    assign dn_data   = r_main_data;
    assign dn_ctrl   = r_main_ctrl;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
